// File: rtl/ieee754_sub_seq_pkg.sv
// Shared single-precision field definitions, constants and types for the
// FP add/subtract datapath.
package ieee754_sub_seq_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int MAG_W  = 27;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN       = 32'h7FC00000;
  localparam logic [31:0] POS_INF    = 32'h7F800000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_PACK,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_DENORM,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } op_class_t;

  // mag = {hidden, mantissa[22:0], guard[2:0]}
  typedef struct packed {
    logic                 sign;
    logic [EXP_W-1:0]     exp;
    logic [MAG_W-1:0]     mag;
  } unpacked_t;

endpackage

// File: rtl/ieee754_sub_seq_if.sv
// Operand/result handshake bundle for the sequential subtractor.
interface ieee754_sub_seq_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] z;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, z, out_valid, busy
  );

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, z, out_valid, busy
  );
endinterface

// File: rtl/ieee754_sub_seq_unpack.sv
// Classifies one single-precision operand and expands it to sign/exp/27-bit
// magnitude; denormals are flushed to a signed zero.
module ieee754_unpack
  import ieee754_sub_seq_pkg::*;
(
  input  logic [31:0] op,
  output unpacked_t   u,
  output op_class_t   cls
);

  logic [EXP_W-1:0]  exp_field;
  logic [MANT_W-1:0] mant_field;

  assign exp_field  = op[MANT_W +: EXP_W];
  assign mant_field = op[MANT_W-1:0];

  always_comb begin
    u   = '{sign: op[31], exp: exp_field, mag: {1'b1, mant_field, 3'b000}};
    cls = CLS_NORMAL;
    if (exp_field == '0) begin
      u.exp = '0;
      u.mag = '0;
      cls   = (mant_field == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (exp_field == '1) begin
      cls = (mant_field == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/ieee754_sub_seq.sv
// Multi-cycle single-precision subtractor Z = A - B: bit-serial alignment and
// normalisation, truncating (round-toward-zero) result packing.
module ieee754_sub_seq
  import ieee754_sub_seq_pkg::*;
#(
  parameter int ALIGN_MAX = 26
) (
  input  logic              clk,
  input  logic              rst,
  ieee754_sub_seq_if.slave  bus
);

  logic [31:0] ops [2];
  unpacked_t   up  [2];
  op_class_t   cls [2];

  // B enters with its sign inverted so the datapath only ever adds signed values
  assign ops[0] = bus.a;
  assign ops[1] = {~bus.b[31], bus.b[30:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      ieee754_unpack u_unpack (
        .op  (ops[gi]),
        .u   (up[gi]),
        .cls (cls[gi])
      );
    end
  endgenerate

  state_t      state_reg;
  logic        in_ready_reg, out_valid_reg, busy_reg;
  logic [31:0] z_reg, zspec_reg;
  logic        special_reg;
  logic        sx_reg, sy_reg;
  logic [8:0]  ex_reg;
  logic [26:0] mx_reg, my_reg;
  logic [7:0]  diff_reg;
  logic [27:0] sum_reg;

  logic        a_larger, any_nan, inf_a, inf_b, is_special;
  unpacked_t   x_op, y_op;
  logic [7:0]  exp_diff, d_cap;
  logic [31:0] spec_z, packed_z;
  logic [27:0] sum_comb;

  assign a_larger = {up[0].exp, up[0].mag} >= {up[1].exp, up[1].mag};
  assign x_op     = a_larger ? up[0] : up[1];
  assign y_op     = a_larger ? up[1] : up[0];
  assign exp_diff = x_op.exp - y_op.exp;
  assign d_cap    = (exp_diff > 8'(ALIGN_MAX)) ? 8'(ALIGN_MAX) : exp_diff;

  assign any_nan    = (cls[0] == CLS_NAN) || (cls[1] == CLS_NAN);
  assign inf_a      = (cls[0] == CLS_INF);
  assign inf_b      = (cls[1] == CLS_INF);
  assign is_special = any_nan || inf_a || inf_b;

  always_comb begin
    spec_z = QNAN;
    if (!any_nan && !(inf_a && inf_b && (up[0].sign != up[1].sign))) begin
      spec_z = inf_a ? {up[0].sign, POS_INF[30:0]} : {up[1].sign, POS_INF[30:0]};
    end
  end

  assign sum_comb = (sx_reg == sy_reg) ? ({1'b0, mx_reg} + {1'b0, my_reg})
                                       : ({1'b0, mx_reg} - {1'b0, my_reg});

  // Zero result is always +0; a sub-normal result flushes to signed zero
  always_comb begin
    packed_z = {sx_reg, ex_reg[7:0], sum_reg[25:3]};
    if (sum_reg == '0) begin
      packed_z = 32'h0;
    end else if (ex_reg > 9'd254) begin
      packed_z = {sx_reg, MAX_FINITE[30:0]};
    end else if (!sum_reg[26]) begin
      packed_z = {sx_reg, 31'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      z_reg         <= 32'h0;
      zspec_reg     <= 32'h0;
      special_reg   <= 1'b0;
      sx_reg        <= 1'b0;
      sy_reg        <= 1'b0;
      ex_reg        <= '0;
      mx_reg        <= '0;
      my_reg        <= '0;
      diff_reg      <= '0;
      sum_reg       <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            sx_reg       <= x_op.sign;
            sy_reg       <= y_op.sign;
            ex_reg       <= {1'b0, x_op.exp};
            mx_reg       <= x_op.mag;
            my_reg       <= y_op.mag;
            diff_reg     <= d_cap;
            special_reg  <= is_special;
            zspec_reg    <= spec_z;
            state_reg    <= is_special ? ST_PACK : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (diff_reg == '0) begin
            state_reg <= ST_ADD;
          end else begin
            my_reg   <= {1'b0, my_reg[26:2], my_reg[1] | my_reg[0]};
            diff_reg <= diff_reg - 8'd1;
            if (diff_reg == 8'd1) state_reg <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_reg   <= sum_comb;
          state_reg <= (sum_comb == '0) ? ST_PACK : ST_NORM;
        end
        ST_NORM: begin
          // Leave on the same edge as the last shift so each shift costs one cycle
          if (sum_reg[27]) begin
            sum_reg   <= {1'b0, sum_reg[27:2], sum_reg[1] | sum_reg[0]};
            ex_reg    <= ex_reg + 9'd1;
            state_reg <= ST_PACK;
          end else if (sum_reg[26] || ex_reg <= 9'd1) begin
            state_reg <= ST_PACK;
          end else begin
            sum_reg <= {sum_reg[26:0], 1'b0};
            ex_reg  <= ex_reg - 9'd1;
            if (sum_reg[25] || ex_reg == 9'd2) state_reg <= ST_PACK;
          end
        end
        ST_PACK: begin
          z_reg         <= special_reg ? zspec_reg : packed_z;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy_reg;
  assign bus.z         = z_reg;

endmodule
